// File: rtl/obj_mem_arbiter.sv
// obj_mem_arbiter: shares the single-port 32 x 144 object memory between the
// matrix unit (read/write) and the clipping unit (read-only frame scan).
// One access per cycle; grants are combinational from the priority state and
// the requests, and read data returns one cycle later to the issuing side.
// While a clip frame is active the clipper has priority, but a starvation
// counter forces a matrix grant after STARVE_MAX consecutive clip grants.
// Optional build macro OBJ_ARB_STATS_EN adds stall_cnt / force_cnt outputs.
module obj_mem_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 144,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mat_req,
    input  logic              mat_we,
    input  logic [ADDR_W-1:0] mat_addr,
    input  logic [DATA_W-1:0] mat_wdata,
    output logic              mat_gnt,
    output logic              mat_rvalid,
    output logic [DATA_W-1:0] mat_rdata,
    input  logic              clip_req,
    input  logic [ADDR_W-1:0] clip_addr,
    input  logic              clip_frame,
    output logic              clip_gnt,
    output logic              clip_rvalid,
    output logic [DATA_W-1:0] clip_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              writing
`ifdef OBJ_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [7:0]        force_cnt
`endif
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic [1:0] {
        MAT_PRI   = 2'd0,
        CLIP_PRI  = 2'd1,
        FORCE_MAT = 2'd2
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] starve_cnt_reg;
    logic [7:0] starve_cnt_next;
    logic       rd_valid_reg;
    logic       rd_owner_reg;   // 1 = outstanding read belongs to the clipper

    // Grant selection: priority comes from the registered state only, so a
    // clip_frame edge takes effect on the following cycle.
    always_comb begin
        mat_gnt  = 1'b0;
        clip_gnt = 1'b0;
        case (state_reg)
            CLIP_PRI: begin
                if (clip_req)     clip_gnt = 1'b1;
                else if (mat_req) mat_gnt  = 1'b1;
            end
            default: begin
                // MAT_PRI and FORCE_MAT both favour the matrix unit
                if (mat_req)       mat_gnt  = 1'b1;
                else if (clip_req) clip_gnt = 1'b1;
            end
        endcase
    end

    // Starvation counter and next-state logic; FORCE_MAT is entered as soon as
    // the counter reaches the limit so the matrix wins on the very next cycle.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!mat_req || !clip_frame || mat_gnt)
            starve_cnt_next = 8'd0;
        else if (clip_gnt && (starve_cnt_reg < STARVE_LIM))
            starve_cnt_next = starve_cnt_reg + 8'd1;

        state_next = clip_frame ? CLIP_PRI : MAT_PRI;
        if ((state_reg == CLIP_PRI) && clip_frame && mat_req &&
            (starve_cnt_next == STARVE_LIM))
            state_next = FORCE_MAT;
    end

    // Priority state and starvation counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= MAT_PRI;
            starve_cnt_reg <= 8'd0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Memory port is a plain mux of whichever requester holds the grant.
    always_comb begin
        mem_en    = mat_gnt | clip_gnt;
        mem_we    = mat_gnt & mat_we;
        writing   = mat_gnt & mat_we;
        mem_addr  = mat_gnt ? mat_addr : (clip_gnt ? clip_addr : '0);
        mem_wdata = mat_gnt ? mat_wdata : '0;
    end

    // Remember who issued each read so the returning word is flagged for them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
            rd_owner_reg <= 1'b0;
        end else begin
            rd_valid_reg <= mem_en & ~mem_we;
            rd_owner_reg <= clip_gnt;
        end
    end

    assign mat_rvalid  = rd_valid_reg & ~rd_owner_reg;
    assign clip_rvalid = rd_valid_reg &  rd_owner_reg;
    assign mat_rdata   = mem_rdata;
    assign clip_rdata  = mem_rdata;

`ifdef OBJ_ARB_STATS_EN
    // Saturating counters of matrix stall cycles and forced matrix grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            force_cnt <= 8'd0;
        end else begin
            if (mat_req && !mat_gnt && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if ((state_next == FORCE_MAT) && (force_cnt != 8'hFF))
                force_cnt <= force_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_obj_mem_arbiter.sv
// Bench for obj_mem_arbiter: directed table, hand-written multi-cycle
// sequences and randomized traffic compared against a behavioural model.
module tb_obj_mem_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 144;
    localparam int SMAX = 8;
    localparam logic [DW-1:0] DATA_A = {{8{16'h1234}}, 16'hBEEF};

    logic          clk = 1'b0;
    logic          rst;
    logic          mat_req, mat_we, clip_req, clip_frame;
    logic [AW-1:0] mat_addr, clip_addr;
    logic [DW-1:0] mat_wdata;
    logic          mat_gnt, mat_rvalid, clip_gnt, clip_rvalid;
    logic [DW-1:0] mat_rdata, clip_rdata;
    logic          mem_en, mem_we, writing;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef OBJ_ARB_STATS_EN
    logic [15:0]   stall_cnt;
    logic [7:0]    force_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    obj_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .mat_req(mat_req), .mat_we(mat_we), .mat_addr(mat_addr), .mat_wdata(mat_wdata),
        .mat_gnt(mat_gnt), .mat_rvalid(mat_rvalid), .mat_rdata(mat_rdata),
        .clip_req(clip_req), .clip_addr(clip_addr), .clip_frame(clip_frame),
        .clip_gnt(clip_gnt), .clip_rvalid(clip_rvalid), .clip_rdata(clip_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .writing(writing)
`ifdef OBJ_ARB_STATS_EN
        , .stall_cnt(stall_cnt), .force_cnt(force_cnt)
`endif
    );

    // Object memory behind the arbiter: one-cycle registered read.
    logic [DW-1:0] tb_mem [0:31];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    function automatic logic [DW-1:0] init_word(input int i);
        logic [15:0] w;
        w = 16'hC000 + 16'(i);
        return {9{w}};
    endfunction

    typedef struct {
        logic          mat_req;
        logic          mat_we;
        logic [AW-1:0] mat_addr;
        logic [DW-1:0] mat_wdata;
        logic          clip_req;
        logic [AW-1:0] clip_addr;
        logic          clip_frame;
    } vin_t;

    typedef struct {
        vin_t          v;
        logic          e_mg, e_cg, e_wr, e_mrv, e_crv;
        logic [DW-1:0] e_data;
    } row_t;

    function automatic vin_t mkv(input logic mr, input logic mw, input int ma,
                                 input logic [DW-1:0] md, input logic cr,
                                 input int ca, input logic cf);
        vin_t v;
        v.mat_req = mr; v.mat_we = mw; v.mat_addr = AW'(ma); v.mat_wdata = md;
        v.clip_req = cr; v.clip_addr = AW'(ca); v.clip_frame = cf;
        return v;
    endfunction

    function automatic row_t mkrow(input vin_t v, input logic mg, input logic cg,
                                   input logic wr, input logic mrv, input logic crv,
                                   input logic [DW-1:0] d);
        row_t r;
        r.v = v; r.e_mg = mg; r.e_cg = cg; r.e_wr = wr;
        r.e_mrv = mrv; r.e_crv = crv; r.e_data = d;
        return r;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Priority owner: clip while the previous cycle saw clip_frame, except for
    // one forced matrix cycle after SMAX clip grants taken while matrix waited.
    logic [DW-1:0] m_mem [0:31];
    logic          m_clip_prio, m_force;
    int            m_streak;
    logic          p_valid, p_owner_clip;
    logic [DW-1:0] p_data;
    logic          m_mat_g, m_clip_g;

    task automatic model_reset();
        m_clip_prio = 1'b0; m_force = 1'b0; m_streak = 0;
        p_valid = 1'b0; p_owner_clip = 1'b0; p_data = '0;
        m_mat_g = 1'b0; m_clip_g = 1'b0;
    endtask

    task automatic model_check(input vin_t v);
        logic mg, cg, fn;
        mg = 1'b0; cg = 1'b0;
        if (m_clip_prio && !m_force) begin
            if (v.clip_req) cg = 1'b1; else if (v.mat_req) mg = 1'b1;
        end else begin
            if (v.mat_req) mg = 1'b1; else if (v.clip_req) cg = 1'b1;
        end
        chk1("mat_gnt", mat_gnt, mg);
        chk1("clip_gnt", clip_gnt, cg);
        chk1("writing", writing, mg & v.mat_we);
        chk1("mem_en", mem_en, mg | cg);
        chk1("mem_we", mem_we, mg & v.mat_we);
        if (mg || cg) chka("mem_addr", mem_addr, mg ? v.mat_addr : v.clip_addr);
        if (mg && v.mat_we) chkd("mem_wdata", mem_wdata, v.mat_wdata);
        chk1("mat_rvalid", mat_rvalid, p_valid & ~p_owner_clip);
        chk1("clip_rvalid", clip_rvalid, p_valid & p_owner_clip);
        if (p_valid && !p_owner_clip) chkd("mat_rdata", mat_rdata, p_data);
        if (p_valid && p_owner_clip)  chkd("clip_rdata", clip_rdata, p_data);
        // advance
        p_valid      = (mg && !v.mat_we) || cg;
        p_owner_clip = cg;
        p_data       = m_mem[cg ? v.clip_addr : v.mat_addr];
        if (mg && v.mat_we) m_mem[v.mat_addr] = v.mat_wdata;
        if (!v.mat_req || !v.clip_frame || mg) m_streak = 0;
        else if (cg && m_streak < SMAX)        m_streak = m_streak + 1;
        fn = m_clip_prio && !m_force && v.clip_frame && v.mat_req && (m_streak == SMAX);
        m_force     = fn;
        m_clip_prio = v.clip_frame && !fn;
        m_mat_g = mg; m_clip_g = cg;
    endtask

    task automatic step(input vin_t v);
        @(negedge clk);
        mat_req = v.mat_req; mat_we = v.mat_we; mat_addr = v.mat_addr;
        mat_wdata = v.mat_wdata; clip_req = v.clip_req; clip_addr = v.clip_addr;
        clip_frame = v.clip_frame;
        #1;
        model_check(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_mat_gnt"}, mat_gnt, 1'b0);
        chk1({tag, "_clip_gnt"}, clip_gnt, 1'b0);
        chk1({tag, "_mat_rvalid"}, mat_rvalid, 1'b0);
        chk1({tag, "_clip_rvalid"}, clip_rvalid, 1'b0);
        chk1({tag, "_mem_en"}, mem_en, 1'b0);
        chk1({tag, "_mem_we"}, mem_we, 1'b0);
        chk1({tag, "_writing"}, writing, 1'b0);
        chka({tag, "_mem_addr"}, mem_addr, '0);
        chkd({tag, "_mem_wdata"}, mem_wdata, '0);
    endtask

    row_t tbl [10];

    initial begin
        vin_t v;
        vin_t idle0;
        vin_t idle1;
        int   n_force;
        idle0 = mkv(0, 0, 0, '0, 0, 0, 0);
        idle1 = mkv(0, 0, 0, '0, 0, 0, 1);
        for (int i = 0; i < 32; i++) begin
            tb_mem[i] = init_word(i);
            m_mem[i]  = init_word(i);
        end
        rst = 1'b1;
        mat_req = 0; mat_we = 0; mat_addr = '0; mat_wdata = '0;
        clip_req = 0; clip_addr = '0; clip_frame = 0;
        model_reset();

        // ---- reset state ----
        #6;
        check_reset_outputs("reset");
`ifdef OBJ_ARB_STATS_EN
        chka("reset_stall_lo", stall_cnt[AW-1:0], '0);
        chk1("reset_force0", force_cnt[0], 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(idle0);
            chk1("idle_no_rvalid", mat_rvalid | clip_rvalid, 1'b0);
        end

        // ---- directed table ----
        tbl[0] = mkrow(mkv(1, 1, 3, DATA_A, 1, 3, 0), 1, 0, 1, 0, 0, '0);
        tbl[1] = mkrow(mkv(0, 0, 0, '0, 1, 3, 0),     0, 1, 0, 0, 0, '0);
        tbl[2] = mkrow(idle0,                          0, 0, 0, 0, 1, DATA_A);
        tbl[3] = mkrow(mkv(1, 0, 3, '0, 1, 5, 0),     1, 0, 0, 0, 0, '0);
        tbl[4] = mkrow(mkv(0, 0, 0, '0, 1, 5, 0),     0, 1, 0, 1, 0, DATA_A);
        tbl[5] = mkrow(idle0,                          0, 0, 0, 0, 1, init_word(5));
        tbl[6] = mkrow(mkv(1, 0, 1, '0, 0, 0, 0),     1, 0, 0, 0, 0, '0);
        tbl[7] = mkrow(mkv(0, 0, 0, '0, 1, 2, 0),     0, 1, 0, 1, 0, init_word(1));
        tbl[8] = mkrow(mkv(1, 0, 3, '0, 0, 0, 0),     1, 0, 0, 0, 1, init_word(2));
        tbl[9] = mkrow(idle0,                          0, 0, 0, 1, 0, DATA_A);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v);
            chk1("tbl_mat_gnt", mat_gnt, tbl[i].e_mg);
            chk1("tbl_clip_gnt", clip_gnt, tbl[i].e_cg);
            chk1("tbl_writing", writing, tbl[i].e_wr);
            chk1("tbl_mat_rvalid", mat_rvalid, tbl[i].e_mrv);
            chk1("tbl_clip_rvalid", clip_rvalid, tbl[i].e_crv);
            if (tbl[i].e_mrv) chkd("tbl_mat_rdata", mat_rdata, tbl[i].e_data);
            if (tbl[i].e_crv) chkd("tbl_clip_rdata", clip_rdata, tbl[i].e_data);
            chk1("tbl_rv_exclusive", mat_rvalid & clip_rvalid, 1'b0);
        end

        // ---- starvation: 8 clip grants, matrix on the 9th cycle ----
        step(idle1);
        for (int i = 0; i < 12; i++) begin
            step(mkv(i <= 8, 0, 7, '0, 1, i, 1));
            chk1("starve_mat_gnt", mat_gnt, i == 8);
            chk1("starve_clip_gnt", clip_gnt, i != 8);
            chk1("starve_mat_rvalid", mat_rvalid, i == 9);
            chk1("starve_clip_rvalid", clip_rvalid, (i >= 1) && (i != 9));
            if (i == 9) chkd("starve_mat_rdata", mat_rdata, init_word(7));
        end
`ifdef OBJ_ARB_STATS_EN
        chkd("stats_stall_cnt", {128'd0, stall_cnt}, {128'd0, 16'd8});
        chkd("stats_force_cnt", {136'd0, force_cnt}, {136'd0, 8'd1});
`endif

        // ---- clip_frame falls while matrix waits ----
        step(idle1);
        for (int j = 0; j < 5; j++) begin
            step(mkv(1, 0, 9, '0, 1, j, j < 3));
            chk1("fall_clip_gnt", clip_gnt, j <= 3);
            chk1("fall_mat_gnt", mat_gnt, j == 4);
        end
        step(idle0);

        // ---- randomized traffic against the model ----
        n_force = 0;
        v = idle0;
        for (int c = 0; c < 2000; c++) begin
            if (!(v.mat_req && !m_mat_g)) begin
                v.mat_req   = ($urandom_range(0, 2) != 0);
                v.mat_we    = $urandom_range(0, 1) == 1;
                v.mat_addr  = AW'($urandom_range(0, 31));
                v.mat_wdata = {16'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (!(v.clip_req && !m_clip_g)) begin
                v.clip_req  = ($urandom_range(0, 3) != 0);
                v.clip_addr = AW'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 31) == 0) v.clip_frame = ~v.clip_frame;
            step(v);
            if (m_force) n_force++;
            chk1("rand_rv_exclusive", mat_rvalid & clip_rvalid, 1'b0);
        end
        $display("random phase done forced_cycles=%0d", n_force);

        // ---- reset while a read is outstanding ----
        step(mkv(1, 0, 4, '0, 0, 0, 0));
        chk1("rstread_mat_gnt", mat_gnt, 1'b1);
        rst = 1'b1;
        mat_req = 0; mat_we = 0; clip_req = 0; clip_frame = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("rstread");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(idle0);
            chk1("rstread_no_rvalid", mat_rvalid | clip_rvalid, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
